// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM states, default parameters and accumulator sizing for fir_stream
package fir_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_COEF_W = 6;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_TAPS   = 8;
    localparam int DEF_SHIFT  = 0;
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with synchronous clear and enable
module fir_mac import fir_pkg::*; #(
    parameter int A_W   = DEF_COEF_W,
    parameter int B_W   = DEF_DATA_W,
    parameter int ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_TAPS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_d, acc_q;
    always_comb begin
        prod  = a * b;
        acc_d = clr ? '0 : en ? acc_q + ACC_W'(prod) : acc_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    assign acc = acc_q;
endmodule

// File: rtl/fir_stream.sv
// fir_stream: streaming FIR with loadable coefficients and one serial MAC;
// define FIR_SATURATE_EN to clamp the output instead of wrapping it.
module fir_stream import fir_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        s_axis_fir_tdata,
    input  logic                     s_axis_fir_tvalid,
    input  logic                     s_set_coeffs,
    output logic                     s_axis_fir_tready,
    output logic [OUT_W-1:0]         m_axis_fir_tdata,
    output logic                     m_axis_fir_tvalid,
    input  logic                     m_axis_fir_tready,
    output logic [(OUT_W+7)/8-1:0]   m_axis_fir_tkeep
);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int KW    = $clog2(TAPS);
`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;
`endif

    state_t                   state_q, state_d;
    logic [KW-1:0]            idx_q, idx_d, k_q, k_d;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [DATA_W-1:0] x_d [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic [OUT_W-1:0]         tdata_q, tdata_d, out_w;
    logic                     tvalid_q, tvalid_d, tready_q;
    logic                     accept;
    logic signed [ACC_W-1:0]  acc, acc_sh;

    assign accept = tready_q & s_axis_fir_tvalid;

    fir_mac #(.A_W(COEF_W), .B_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept & ~s_set_coeffs),
        .en      (state_q == COMPUTE),
        .a       (coef_q[k_q]),
        .b       (x_q[k_q]),
        .acc     (acc)
    );

    always_comb begin
        acc_sh = acc >>> SHIFT;
`ifdef FIR_SATURATE_EN
        out_w = acc_sh > SAT_HI ? OUT_W'(SAT_HI) : acc_sh < SAT_LO ? OUT_W'(SAT_LO) : OUT_W'(acc_sh);
`else
        out_w = OUT_W'(acc_sh);
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        k_d      = k_q;
        x_d      = x_q;
        coef_d   = coef_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        case (state_q)
            IDLE: if (accept) begin
                if (s_set_coeffs) begin
                    coef_d[idx_q] = COEF_W'(signed'(s_axis_fir_tdata));
                    idx_d         = idx_q == KW'(TAPS - 1) ? '0 : idx_q + 1'b1;
                end else begin
                    for (int i = TAPS - 1; i > 0; i--) x_d[i] = x_q[i-1];
                    x_d[0]  = s_axis_fir_tdata;
                    k_d     = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                k_d     = k_q == KW'(TAPS - 1) ? '0 : k_q + 1'b1;
                state_d = k_q == KW'(TAPS - 1) ? OUTPUT : COMPUTE;
            end
            // first OUTPUT cycle registers the result, then it is held for the consumer
            OUTPUT: if (!tvalid_q) begin
                tvalid_d = 1'b1;
                tdata_d  = out_w;
            end else if (m_axis_fir_tready) begin
                tvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            k_q      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tready_q <= state_d == IDLE;
        end

    assign s_axis_fir_tready = tready_q;
    assign m_axis_fir_tdata  = tdata_q;
    assign m_axis_fir_tvalid = tvalid_q;
    assign m_axis_fir_tkeep  = {((OUT_W + 7) / 8){tvalid_q}};
endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: randomized self-checking bench for fir_stream against a sum-of-products model
module tb_fir_stream;
    localparam int DATA_W = 6;
    localparam int COEF_W = 6;
    localparam int OUT_W  = 8;
    localparam int TAPS   = 8;
    localparam int SHIFT  = 0;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_set = 1'b0;
    logic              s_ready;
    logic [OUT_W-1:0]  m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [0:0]        m_keep;

    int total = 0;
    int bad = 0;
    bit hs_err = 1'b0;
    int mc [TAPS];
    int hist [TAPS];
    int midx;

    fir_stream #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .s_axis_fir_tdata  (s_data),
        .s_axis_fir_tvalid (s_valid),
        .s_set_coeffs      (s_set),
        .s_axis_fir_tready (s_ready),
        .m_axis_fir_tdata  (m_data),
        .m_axis_fir_tvalid (m_valid),
        .m_axis_fir_tready (m_ready),
        .m_axis_fir_tkeep  (m_keep)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [DATA_W-1:0] d);
        return int'($signed(d));
    endfunction

    function automatic logic [OUT_W-1:0] model_out();
        int s = 0;
        for (int i = 0; i < TAPS; i++) s += mc[i] * hist[i];
        s = s >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return OUT_W'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mc[i] = 0;
            hist[i] = 0;
        end
        mc[0] = 1;
        midx = 0;
    endtask

    task automatic model_coef(input logic [DATA_W-1:0] d);
        mc[midx] = sx(d);
        midx = (midx + 1) % TAPS;
    endtask

    task automatic model_sample(input logic [DATA_W-1:0] d);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sx(d);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic set);
        int n = 0;
        s_data = d;
        s_set = set;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) hs_err = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_set = 1'b0;
    endtask

    task automatic get_out(output logic [OUT_W-1:0] d, output int lat);
        lat = 0;
        while (!m_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        d = m_data;
        if (m_valid && m_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got valid=%b data=%h keep=%b ready=%b exp all 0", m_valid, m_data, m_keep, s_ready);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_early got ready=%b exp 0", s_ready);
        end
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_edge got ready=%b valid=%b exp ready=1 valid=0", s_ready, m_valid);
        end
    endtask

    task automatic test_passthrough();
        logic [OUT_W-1:0] got;
        int lat;
        send(6'b111111, 1'b0);
        model_sample(6'b111111);
        get_out(got, lat);
        total++;
        if (got !== 8'hFF || lat != TAPS + 1) begin
            bad++;
            $display("FAIL passthrough_neg got=%h lat=%0d exp=ff lat=%0d", got, lat, TAPS + 1);
        end
        send(6'd0, 1'b0);
        model_sample(6'd0);
        m_ready = 1'b0;
        get_out(got, lat);
        total++;
        if (got !== 8'h00 || m_keep !== 1'b1 || lat != TAPS + 1) begin
            bad++;
            $display("FAIL passthrough_zero got=%h keep=%b lat=%0d exp=00 keep=1 lat=%0d", got, m_keep, lat, TAPS + 1);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_accumulate();
        logic [OUT_W-1:0] got, exp, last;
        int lat;
        for (int i = 0; i < TAPS; i++) begin
            send(6'd1, 1'b1);
            model_coef(6'd1);
        end
        for (int i = 0; i < TAPS; i++) begin
            send(6'd31, 1'b0);
            model_sample(6'd31);
            exp = model_out();
            get_out(got, lat);
            total++;
            if (got !== exp || lat != TAPS + 1) begin
                bad++;
                $display("FAIL accumulate[%0d] got=%h lat=%0d exp=%h lat=%0d", i, got, lat, exp, TAPS + 1);
            end
            last = got;
        end
`ifdef FIR_SATURATE_EN
        exp = 8'd127;
`else
        exp = 8'hF8;
`endif
        total++;
        if (last !== exp) begin
            bad++;
            $display("FAIL accumulate_final got=%h exp=%h", last, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] got, exp;
        logic [DATA_W-1:0] d;
        int lat;
        d = DATA_W'($urandom);
        m_ready = 1'b0;
        send(d, 1'b0);
        model_sample(d);
        exp = model_out();
        get_out(got, lat);
        total++;
        if (got !== exp || lat != TAPS + 1) begin
            bad++;
            $display("FAIL backpressure_first got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, TAPS + 1);
        end
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = DATA_W'($urandom);
            s_set = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if (m_data !== exp || m_valid !== 1'b1 || s_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold[%0d] got data=%h valid=%b ready=%b exp data=%h valid=1 ready=0", i, m_data, m_valid, s_ready, exp);
            end
        end
        s_valid = 1'b0;
        s_set = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure_release got valid=%b ready=%b exp valid=0 ready=1", m_valid, s_ready);
        end
        d = DATA_W'($urandom);
        send(d, 1'b0);
        model_sample(d);
        exp = model_out();
        get_out(got, lat);
        total++;
        if (got !== exp || lat != TAPS + 1) begin
            bad++;
            $display("FAIL backpressure_ignored_words got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, TAPS + 1);
        end
    endtask

    task automatic test_reset_mid_compute();
        logic [OUT_W-1:0] got;
        int lat;
        send(6'd2, 1'b1);
        model_coef(6'd2);
        send(6'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_compute got valid=%b data=%h keep=%b ready=%b exp all 0", m_valid, m_data, m_keep, s_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_recover got ready=%b valid=%b exp ready=1 valid=0", s_ready, m_valid);
        end
        send(6'd5, 1'b0);
        model_sample(6'd5);
        get_out(got, lat);
        total++;
        if (got !== 8'd5 || lat != TAPS + 1) begin
            bad++;
            $display("FAIL reset_mid_passthrough got=%h lat=%0d exp=05 lat=%0d", got, lat, TAPS + 1);
        end
    endtask

    task automatic test_coef_wrap();
        logic [OUT_W-1:0] got, exp;
        int lat;
        int imp [TAPS] = '{9, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 1; i <= TAPS + 1; i++) begin
            send(DATA_W'(i), 1'b1);
            model_coef(DATA_W'(i));
        end
        for (int i = 0; i < TAPS; i++) begin
            send(6'd0, 1'b0);
            model_sample(6'd0);
            exp = model_out();
            get_out(got, lat);
            total++;
            if (got !== exp || lat != TAPS + 1) begin
                bad++;
                $display("FAIL wrap_flush[%0d] got=%h lat=%0d exp=%h lat=%0d", i, got, lat, exp, TAPS + 1);
            end
        end
        for (int i = 0; i < TAPS; i++) begin
            send((i == 0) ? 6'd1 : 6'd0, 1'b0);
            get_out(got, lat);
            total++;
            if (got !== OUT_W'(imp[i]) || lat != TAPS + 1) begin
                bad++;
                $display("FAIL wrap_impulse[%0d] got=%h lat=%0d exp=%h lat=%0d", i, got, lat, OUT_W'(imp[i]), TAPS + 1);
            end
        end
        model_sample(6'd1);
        for (int i = 1; i < TAPS; i++) model_sample(6'd0);
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] got, exp;
        logic [DATA_W-1:0] d;
        int lat;
        bit bp;
        for (int n = 0; n < 60; n++) begin
            d = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                send(d, 1'b1);
                model_coef(d);
            end else begin
                bp = 1'($urandom_range(0, 1));
                m_ready = !bp;
                send(d, 1'b0);
                model_sample(d);
                exp = model_out();
                get_out(got, lat);
                total++;
                if (got !== exp || lat != TAPS + 1) begin
                    bad++;
                    $display("FAIL random[%0d] got=%h lat=%0d exp=%h lat=%0d", n, got, lat, exp, TAPS + 1);
                end
                if (bp) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    total++;
                    if (m_valid !== 1'b1 || m_data !== exp) begin
                        bad++;
                        $display("FAIL random_hold[%0d] got valid=%b data=%h exp valid=1 data=%h", n, m_valid, m_data, exp);
                    end
                    m_ready = 1'b1;
                    @(posedge clk); #1;
                end
            end
        end
        total++;
        if (hs_err !== 1'b0) begin
            bad++;
            $display("FAIL input_handshake_timeout got=%b exp=0", hs_err);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_accumulate();
        test_backpressure();
        test_reset_mid_compute();
        test_coef_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
